downsizing: RTL



---
 rtl/downsizing_pkg.sv | 17 +
 rtl/downsizing.sv | 99 +++++++++
 2 files changed

// File: rtl/downsizing_pkg.sv
// Purpose : shared types and constants for the 2W-to-W stream downsizer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package downsizing_pkg;

    // Default narrow (output) data width; the input side is twice this.
    localparam int DOWNSIZING_W = 40;

    // EMPTY: nothing held. UPPER: word held, upper half not yet sent.
    // LOWER: upper half sent, lower half pending.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        UPPER = 2'd1,
        LOWER = 2'd2
    } state_t;

endpackage : downsizing_pkg

// File: rtl/downsizing.sv
// Purpose : AXI-Stream width converter, one 2W input beat -> two W output beats (upper half first).
// Latency : word accepted at edge N shows its upper half in cycle N+1, lower half no earlier than N+2.
// Backpressure: out_tvalid/out_tdata hold until accepted; in_tready rises only when the held word is draining.
//
// Ports:
//   aclk, aresetn          clock; synchronous active-low reset
//   in_tdata/in_tvalid/in_tready     wide (2W) input stream
//   out_tdata/out_tvalid/out_tready  narrow (W) output stream
//   in_tlast/out_tlast     packet boundary, only when DOWNSIZING_TLAST_EN is defined
module downsizing
    import downsizing_pkg::*;
#(
    parameter int W = DOWNSIZING_W
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic [2*W-1:0] in_tdata,
    input  logic           in_tvalid,
    output logic           in_tready,
`ifdef DOWNSIZING_TLAST_EN
    input  logic           in_tlast,
    output logic           out_tlast,
`endif
    output logic [W-1:0]   out_tdata,
    output logic           out_tvalid,
    input  logic           out_tready
);

    state_t         state_q, state_d;
    logic [2*W-1:0] hold_data_q, hold_data_d;
    logic           in_hs;
    logic           out_hs;

    // Both handshake qualifiers come from the state register and out_tready
    // only, so there is no combinational path from in_tvalid to any output.
    always_comb begin
        out_tvalid = (state_q != EMPTY);
        in_tready  = (state_q == EMPTY) | ((state_q == LOWER) & out_tready);
        out_tdata  = (state_q == LOWER) ? hold_data_q[W-1:0] : hold_data_q[2*W-1:W];
        in_hs      = in_tvalid & in_tready;
        out_hs     = out_tvalid & out_tready;
    end

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        if (in_hs) begin
            hold_data_d = in_tdata;
        end
        case (state_q)
            EMPTY: begin
                if (in_hs) state_d = UPPER;
            end
            UPPER: begin
                if (out_hs) state_d = LOWER;
            end
            LOWER: begin
                // Refill in the same cycle the lower half leaves: no bubble.
                if (out_hs) state_d = in_hs ? UPPER : EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data is qualified by state, so it needs no reset.
    always_ff @(posedge aclk) begin
        hold_data_q <= hold_data_d;
    end

`ifdef DOWNSIZING_TLAST_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (in_hs) begin
            last_d = in_tlast;
        end
        // The boundary belongs to the final narrow beat of the word.
        out_tlast = last_q & (state_q == LOWER);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule : downsizing
